// File: rtl/inst_queue_pkg.sv
// Shared pipeline constants for the fetch/decode instruction queue,
// plus lane-slice helpers for the flattened multi-lane buses.
package inst_queue_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned IQ_ENTRY_W = INSTR_W + PC_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pcplus4;
  } iq_entry_t;

  function automatic int unsigned iq_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

`ifndef IQ_LANE
`define IQ_LANE(bus, i, w) bus[(i)*(w) +: (w)]
`endif

// File: rtl/iq_storage.sv
// DEPTH x DATA_W entry array: WAYS write ports and WAYS combinational read
// ports, each addressed as base pointer plus lane offset (mod DEPTH).
module iq_storage
  import inst_queue_pkg::*;
#(
  parameter int unsigned DATA_W = IQ_ENTRY_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WAYS   = 2
) (
  input  logic                       clk,
  input  logic [WAYS-1:0]            i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_base,
  input  logic [WAYS*DATA_W-1:0]     i_wr_data,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_base,
  output logic [WAYS*DATA_W-1:0]     o_rd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Pointer arithmetic is PTR_W wide, so lane offsets wrap at the array top.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (i_we[i]) begin
        r_mem[i_wr_base + PTR_W'(i)] <= `IQ_LANE(i_wr_data, i, DATA_W);
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      `IQ_LANE(o_rd_data, i, DATA_W) = r_mem[i_rd_base + PTR_W'(i)];
    end
  end

endmodule

// File: rtl/inst_queue.sv
// Multi-lane instruction queue between fetch and decode: up to WAYS pushes
// and WAYS pops per cycle, synchronous flush on redirect, async active-low reset.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DATA_W = IQ_ENTRY_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned WAYS   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [$clog2(WAYS+1)-1:0]    in_count,
  input  logic [WAYS*DATA_W-1:0]       in_data,
  output logic                         in_ready,
  output logic [WAYS-1:0]              out_valid,
  output logic [WAYS*DATA_W-1:0]       out_data,
  input  logic [$clog2(WAYS+1)-1:0]    pop_count,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [CNT_W-1:0]        r_count;

  logic [CNT_W-1:0]        w_free;
  logic [CNT_W-1:0]        w_push_n;
  logic [CNT_W-1:0]        w_pop_n;
  logic [WAYS-1:0]         w_we;
  logic [WAYS*DATA_W-1:0]  w_rd_data;

  // Ready looks only at the registered count; same-cycle pops give no credit.
  assign w_free   = CNT_W'(DEPTH) - r_count;
  assign in_ready = (w_free >= CNT_W'(WAYS));

  assign w_push_n = in_ready ? CNT_W'(iq_min(32'(in_count), WAYS)) : '0;
  assign w_pop_n  = CNT_W'(iq_min(32'(pop_count), 32'(r_count)));

  always_comb begin
    w_we = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      w_we[i] = !flush && (CNT_W'(i) < w_push_n);
    end
  end

  iq_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .WAYS   (WAYS)
  ) u_storage (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_base (r_wr_ptr),
    .i_wr_data (in_data),
    .i_rd_base (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
      r_count  <= r_count + w_push_n - w_pop_n;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      out_valid[i] = (r_count > CNT_W'(i));
      if (out_valid[i]) begin
        `IQ_LANE(out_data, i, DATA_W) = `IQ_LANE(w_rd_data, i, DATA_W);
      end
    end
  end

  assign occupancy = r_count;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && !flush) begin
      assert (CNT_W'(pop_count) <= r_count)
        else $error("inst_queue: pop_count %0d exceeds occupancy %0d", pop_count, r_count);
    end
  end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed checks of inst_queue against a FIFO-queue model.
module tb_inst_queue;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned WAYS   = 2;
  localparam int unsigned LN_W   = $clog2(WAYS+1);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [LN_W-1:0]          in_count;
  logic [WAYS*DATA_W-1:0]   in_data;
  logic                     in_ready;
  logic [WAYS-1:0]          out_valid;
  logic [WAYS*DATA_W-1:0]   out_data;
  logic [LN_W-1:0]          pop_count;
  logic [CNT_W-1:0]         occupancy;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] q [$];

  inst_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .WAYS   (WAYS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_count  (in_count),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pop_count (pop_count),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check_outputs();
    chk("occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
    chk("in_ready", DATA_W'(in_ready), DATA_W'((DEPTH - q.size()) >= WAYS));
    for (int i = 0; i < WAYS; i++) begin
      chk($sformatf("out_valid[%0d]", i), DATA_W'(out_valid[i]), DATA_W'(i < q.size()));
      chk($sformatf("out_data[%0d]", i), out_data[i*DATA_W +: DATA_W],
          (i < q.size()) ? q[i] : '0);
    end
  endtask

  // Check current outputs, take one clock edge, then apply queue semantics.
  task automatic cycle();
    int  p;
    int  n;
    bit  rdy;
    check_outputs();
    @(posedge clk);
    #1;
    if (!reset || flush) begin
      q.delete();
    end else begin
      rdy = (DEPTH - q.size()) >= WAYS;
      p = (pop_count > q.size()) ? q.size() : int'(pop_count);
      repeat (p) void'(q.pop_front());
      n = (in_count > WAYS) ? WAYS : int'(in_count);
      if (rdy) for (int i = 0; i < n; i++) q.push_back(in_data[i*DATA_W +: DATA_W]);
    end
  endtask

  task automatic drive(input int n, input int pop, input bit fl);
    in_count  = LN_W'(n);
    pop_count = LN_W'(pop);
    flush     = fl;
    for (int i = 0; i < WAYS; i++) in_data[i*DATA_W +: DATA_W] = rnd64();
  endtask

  initial begin
    logic [DATA_W-1:0] tmp;
    reset = 1'b0;
    drive(0, 0, 1'b0);
    #1;

    // Reset held with a push pending: nothing is accepted.
    repeat (3) begin
      drive(2, 0, 1'b0);
      cycle();
    end
    chk("reset_occ", DATA_W'(occupancy), '0);
    chk("reset_ready", DATA_W'(in_ready), DATA_W'(1));
    reset = 1'b1;

    // Fill with four pairs, then a dropped pair, then drain.
    for (int k = 0; k < 4; k++) begin
      drive(2, 0, 1'b0);
      cycle();
      if (k == 2) begin
        chk("fill_occ6", DATA_W'(occupancy), DATA_W'(6));
        chk("fill_ready6", DATA_W'(in_ready), DATA_W'(1));
      end
    end
    chk("full_occ8", DATA_W'(occupancy), DATA_W'(8));
    chk("full_ready", DATA_W'(in_ready), '0);
    drive(2, 0, 1'b0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(0, 2, 1'b0);
      cycle();
    end
    chk("drained", DATA_W'(occupancy), '0);

    // Preload 7 then steady pop-1/push-1 across pointer wrap.
    drive(2, 0, 1'b0); cycle();
    drive(2, 0, 1'b0); cycle();
    drive(2, 0, 1'b0); cycle();
    drive(1, 0, 1'b0); cycle();
    chk("preload7", DATA_W'(occupancy), DATA_W'(7));
    repeat (20) begin
      drive(1, 1, 1'b0);
      cycle();
    end

    // Partial lanes on an empty queue.
    drive(0, 0, 1'b1); cycle();
    drive(1, 0, 1'b0); cycle();
    drive(2, 0, 1'b0); cycle();
    drive(0, 2, 1'b0); cycle();
    chk("partial_valid", DATA_W'(out_valid), DATA_W'(1));
    drive(0, 1, 1'b0); cycle();

    // Flush overrides push and pop in the same cycle.
    drive(2, 0, 1'b0); cycle();
    drive(2, 0, 1'b0); cycle();
    drive(1, 0, 1'b0); cycle();
    chk("preflush_occ5", DATA_W'(occupancy), DATA_W'(5));
    drive(2, 1, 1'b1); cycle();
    chk("flush_occ", DATA_W'(occupancy), '0);
    chk("flush_valid", DATA_W'(out_valid), '0);
    drive(1, 0, 1'b0);
    tmp = in_data[DATA_W-1:0];
    cycle();
    chk("after_flush_q", out_data[DATA_W-1:0], tmp);
    drive(0, 0, 1'b0); cycle();

    // Async reset asserted between edges at occupancy 4.
    drive(2, 0, 1'b0); cycle();
    drive(1, 0, 1'b0); cycle();
    drive(0, 0, 1'b0);
    chk("prereset_occ4", DATA_W'(occupancy), DATA_W'(4));
    #2 reset = 1'b0;
    #1;
    q.delete();
    chk("async_occ", DATA_W'(occupancy), '0);
    chk("async_valid", DATA_W'(out_valid), '0);
    chk("async_data", out_data[DATA_W-1:0], '0);
    @(posedge clk);
    #3 reset = 1'b1;
    drive(2, 0, 1'b0); cycle();
    chk("resume_occ", DATA_W'(occupancy), DATA_W'(2));

    // Random traffic with legal pops and occasional flushes.
    repeat (400) begin
      int maxp;
      maxp = (q.size() < WAYS) ? q.size() : WAYS;
      drive($urandom_range(0, WAYS), $urandom_range(0, maxp), ($urandom_range(0, 15) == 0));
      cycle();
    end
    drive(0, 0, 1'b0);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
